pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Instruction-fetch front end of the single-issue MIPS core. Owns the PC register,
//  drives it to the next-PC calculator, and loads that block's NPC result when decode
//  accepts the current instruction. Fetches from instruction memory over a req/gnt +
//  rvalid handshake and holds the fetched word for decode under a valid/ready handshake.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC value after reset (word aligned)
//  CNT_W     32             width of retired-fetch counter
// PORTS
//  clk          in   1      core clock, all state on rising edge
//  reset        in   1      asynchronous, active-high reset
//  halt         in   1      stop issuing new fetches (level)
//  npc          in   32     next PC from next-PC calculator, valid while inst_valid=1
//  pc           out  32     current PC, to next-PC calculator PC input and datapath
//  imem_req     out  1      instruction memory request
//  imem_addr    out  32     request address (= pc)
//  imem_gnt     in   1      memory accepts request this cycle
//  imem_rvalid  in   1      read data valid
//  imem_rdata   in   32     read data
//  inst         out  32     fetched instruction to decode
//  inst_valid   out  1      inst holds a valid instruction
//  inst_ready   in   1      decode consumes inst this cycle
//  misalign     out  1      sticky: npc[1:0]!=0 was presented at accept
//  fetch_cnt    out  CNT_W  count of instructions accepted by decode
// BEHAVIOUR
//  Reset (async, any state): pc=RESET_PC, state=IDLE, imem_req=0, inst=0, inst_valid=0,
//   misalign=0, fetch_cnt=0. In-flight memory transaction abandoned; later rvalid ignored.
//  FSM states IDLE, REQ, WAIT, HOLD (registered state, Moore outputs):
//   IDLE: imem_req=0. halt=0 -> REQ next cycle. halt=1 or misalign=1 -> stay.
//   REQ:  imem_req=1, imem_addr=pc, held stable until imem_gnt. gnt=1 -> WAIT.
//   WAIT: imem_req=0. rvalid=1 -> inst<=imem_rdata, inst_valid<=1, -> HOLD.
//         rvalid in the same cycle as gnt is not legal; only WAIT samples rvalid.
//   HOLD: inst_valid=1, inst stable. inst_ready=1 -> pc<=npc, inst_valid<=0,
//         fetch_cnt<=fetch_cnt+1 (wraps modulo 2^CNT_W); next state REQ if halt=0,
//         else IDLE. inst_ready=0 -> stay, pc/inst unchanged.
//  halt is sampled only in IDLE and at HOLD accept; halt during REQ/WAIT lets the
//   transaction complete and the instruction is still presented in HOLD.
//  halt and inst_ready both high in HOLD: pc still loads npc, count increments, -> IDLE.
//  Misaligned npc (npc[1:0]!=0) at HOLD accept: pc<=npc unchanged rule, misalign<=1,
//   -> IDLE, no request issued for it; remains in IDLE until reset.
//  Latency: reset release to first imem_req = 2 cycles (IDLE, then REQ). Zero-wait memory
//   (gnt in REQ, rvalid next cycle) with inst_ready=1 gives one instruction per 3 cycles.
//  pc wraps naturally at 32 bits; no special handling of 32'hFFFF_FFFC + 4.
//  Only one outstanding memory transaction, ever.
// TESTING
//  1 Reset release, halt=0, gnt=1, rvalid next cycle, ready=1 -> imem_addr 0x3000,
//    0x3004, 0x3008 (npc=pc+4) at cycles 2, 5, 8; fetch_cnt=3 after third accept.
//  2 Branch: in HOLD at pc=0x3010, npc=0x3040, ready=1 -> next imem_addr=0x3040.
//  3 Backpressure: ready=0 for 5 cycles in HOLD -> inst, pc, inst_valid stable, no
//    imem_req; ready=1 -> single accept, fetch_cnt +1 only.
//  4 gnt delayed 4 cycles -> imem_req/addr held constant all 4; rvalid delayed 3 -> WAIT held.
//  5 halt=1 with ready=1 in HOLD -> pc=npc, state IDLE, imem_req=0 until halt=0, then
//    REQ at new pc; npc=0x3042 at accept -> misalign=1, no further requests.
//  6 reset asserted in WAIT, rvalid arrives after release -> ignored, inst_valid=0,
//    first request at 0x3000; fetch_cnt=0xFFFF_FFFF + accept -> 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Instruction-fetch front end of the single-issue MIPS core. Holds the PC and
//   presents it to the next-PC calculator. Fetches one word at a time from
//   instruction memory (req/gnt, then rvalid). Holds the fetched word for decode
//   under a valid/ready handshake. When decode accepts the word, the PC loads
//   the calculator's npc.
//
// Ports
//   clk, reset           core clock; asynchronous active-high reset
//   halt                 stop issuing new fetches (level)
//   npc                  next PC from the next-PC calculator
//   pc                   current PC
//   imem_req/imem_addr   memory request and address (address = pc)
//   imem_gnt             memory accepts the request this cycle
//   imem_rvalid/rdata    read response
//   inst/inst_valid      fetched word to decode and its valid flag
//   inst_ready           decode consumes inst this cycle
//   misalign             sticky flag: a misaligned npc was accepted
//   fetch_cnt            number of instructions accepted by decode
//
// State | Meaning
// IDLE  | no fetch in progress; waiting for halt low (blocked forever by misalign)
// REQ   | imem_req high with imem_addr = pc, waiting for imem_gnt
// WAIT  | request granted, waiting for imem_rvalid
// HOLD  | inst valid for decode, waiting for inst_ready
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic [31:0]      npc,
  output logic [31:0]      pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   load_inst;
  logic   accept;
  logic   npc_misaligned;

  assign npc_misaligned = (npc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      inst      <= 32'h0;
      misalign  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load_inst) begin
        inst <= imem_rdata;
      end
      if (accept) begin
        pc        <= npc;
        fetch_cnt <= fetch_cnt + CNT_W'(1);
        if (npc_misaligned) begin
          misalign <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    load_inst  = 1'b0;
    accept     = 1'b0;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (!halt && !misalign) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Only this state listens to rvalid, so a response to a transaction
        // abandoned by reset can never be captured.
        if (imem_rvalid) begin
          load_inst = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          accept = 1'b1;
          // A misaligned target is loaded into pc but never fetched.
          if (halt || npc_misaligned) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          CNT_W    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             halt;
  logic [31:0]      npc;
  logic [31:0]      pc;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic [31:0]      inst;
  logic             inst_valid;
  logic             inst_ready;
  logic             misalign;
  logic [CNT_W-1:0] fetch_cnt;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .npc         (npc),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .misalign    (misalign),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]      exp_addr_q[$];
  logic [31:0]      exp_inst_q[$];
  logic [31:0]      model_pc;
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  // One complete fetch: wait for the request, grant after gnt_dly cycles,
  // respond after rv_dly cycles, hold ready low rdy_dly cycles, then accept
  // with npc=nxt and halt=hlt. exp_wait < 0 skips the request-latency check.
  task automatic fetch_one(input int gnt_dly, input int rv_dly, input int rdy_dly,
                           input logic [31:0] nxt, input logic hlt,
                           input int exp_wait, input logic expect_next);
    int          w;
    logic [31:0] a;
    logic [31:0] e;
    w = 0;
    while (!imem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!imem_req) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_wait >= 0) chk("req_latency", w, exp_wait);
    a = imem_addr;
    if (exp_addr_q.size() == 0) begin
      chk("unexpected_req", a, 32'hFFFF_FFFF);
    end else begin
      chk("req_addr", a, exp_addr_q.pop_front());
    end
    for (int i = 0; i < gnt_dly; i++) begin
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, a);
      @(negedge clk);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("req_drop", imem_req, 0);
    exp_inst_q.push_back(mem_word(a));
    for (int i = 0; i < rv_dly; i++) begin
      chk("wait_hold", inst_valid, 0);
      chk("wait_noreq", imem_req, 0);
      @(negedge clk);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(a);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    chk("hold_valid", inst_valid, 1);
    e = exp_inst_q.pop_front();
    chk("inst", inst, e);
    chk("pc_hold", pc, model_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      chk("bp_inst", inst, e);
      chk("bp_valid", inst_valid, 1);
      chk("bp_pc", pc, model_pc);
      chk("bp_noreq", imem_req, 0);
      chk("bp_cnt", 32'(fetch_cnt), 32'(exp_cnt));
    end
    npc        = nxt;
    halt       = hlt;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    exp_cnt    = exp_cnt + 1'b1;
    model_pc   = nxt;
    if (nxt[1:0] != 2'b00) exp_mis = 1'b1;
    chk("fetch_cnt", 32'(fetch_cnt), 32'(exp_cnt));
    chk("pc_load", pc, model_pc);
    chk("accept_valid", inst_valid, 0);
    chk("misalign", misalign, exp_mis);
    if (expect_next) exp_addr_q.push_back(nxt);
  endtask

  task automatic model_reset();
    exp_addr_q.delete();
    exp_inst_q.delete();
    model_pc = RESET_PC;
    exp_cnt  = '0;
    exp_mis  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    halt        = 1'b0;
    npc         = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    inst_ready  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_cnt", 32'(fetch_cnt), 0);

    reset = 1'b0;
    exp_addr_q.push_back(RESET_PC);

    // Zero-wait memory, sequential fetch: one instruction every 3 cycles.
    fetch_one(0, 0, 0, model_pc + 32'd4, 1'b0, 1, 1'b1);
    fetch_one(0, 0, 0, model_pc + 32'd4, 1'b0, 0, 1'b1);
    fetch_one(0, 0, 0, model_pc + 32'd4, 1'b0, 0, 1'b1);
    chk("cnt3", 32'(fetch_cnt), 3);
    fetch_one(0, 0, 0, model_pc + 32'd4, 1'b0, 0, 1'b1);

    // Branch from 0x3010 to 0x3040.
    chk("branch_pc", pc, 32'h0000_3010);
    fetch_one(0, 0, 0, 32'h0000_3040, 1'b0, 0, 1'b1);

    // Decode backpressure for 5 cycles.
    fetch_one(0, 0, 5, model_pc + 32'd4, 1'b0, 0, 1'b1);

    // Slow memory; halt raised mid-transaction and kept through the accept.
    halt = 1'b1;
    fetch_one(4, 3, 0, model_pc + 32'd4, 1'b1, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("halt_noreq", imem_req, 0);
      chk("halt_pc", pc, model_pc);
    end
    halt = 1'b0;

    // Resume, then accept a misaligned target.
    fetch_one(0, 0, 0, 32'h0000_3042, 1'b0, 1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mis_noreq", imem_req, 0);
      chk("mis_sticky", misalign, 1);
    end

    // Reset while a transaction is in WAIT; the late rvalid must be ignored.
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_addr_q.push_back(RESET_PC);
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    chk("wr_req", imem_req, 1);
    chk("wr_addr", imem_addr, RESET_PC);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    chk("late_rv_valid", inst_valid, 0);
    chk("late_rv_inst", inst, 0);
    chk("late_rv_cnt", 32'(fetch_cnt), 0);
    chk("late_rv_mis", misalign, 0);
    fetch_one(0, 0, 0, model_pc + 32'd4, 1'b0, 0, 1'b1);

    // Run the counter all the way round.
    for (int i = 1; i < (1 << CNT_W); i++) begin
      fetch_one(0, 0, 0, model_pc + 32'd4, 1'b0, 0, 1'b1);
    end
    chk("cnt_wrap", 32'(fetch_cnt), 0);
    chk("wrap_pc", pc, RESET_PC + 32'd4 * (1 << CNT_W));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
